// File: rtl/sp_ram_dma.sv
// Command-driven fill/copy engine that is the only initiator on a single-port RAM.
// Every output is a register that holds the value for the state being entered.
module sp_ram_dma #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    op_i,
  input  logic [ADDR_WIDTH-1:0]   src_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dst_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  input  logic [DATA_WIDTH-1:0]   fill_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(NB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [LEN_WIDTH-1:0]  ONE        = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_WR = 3'd1,
    CP_RD   = 3'd2,
    CP_WR   = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   src_q;
  logic [ADDR_WIDTH-1:0]   dst_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [DATA_WIDTH-1:0]   fill_q;
  logic                    misaligned;

  // Source alignment only matters when the command actually reads.
  assign misaligned = ((dst_addr_i & ALIGN_MASK) != '0) ||
                      (op_i && ((src_addr_i & ALIGN_MASK) != '0));

  // src_q/dst_q hold the address of the next access of their kind; cnt_q counts writes still owed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      fill_q      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_en_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            fill_q <= fill_data_i;
            if (misaligned) begin
              err_o <= 1'b1;
            end else if (len_i == '0) begin
              state_q <= DONE;
              busy_o  <= 1'b1;
              done_o  <= 1'b1;
            end else begin
              busy_o   <= 1'b1;
              mem_en_o <= 1'b1;
              cnt_q    <= len_i;
              if (!op_i) begin
                state_q     <= FILL_WR;
                mem_we_o    <= 1'b1;
                mem_be_o    <= '1;
                mem_addr_o  <= dst_addr_i;
                mem_wdata_o <= fill_data_i;
                dst_q       <= dst_addr_i + STEP;
              end else begin
                state_q    <= CP_RD;
                mem_we_o   <= 1'b0;
                mem_be_o   <= '0;
                mem_addr_o <= src_addr_i;
                src_q      <= src_addr_i + STEP;
                dst_q      <= dst_addr_i;
              end
            end
          end
        end
        FILL_WR: begin
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_q     <= DONE;
            done_o      <= 1'b1;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end else begin
            mem_addr_o  <= dst_q;
            mem_wdata_o <= fill_q;
            dst_q       <= dst_q + STEP;
          end
        end
        CP_RD: begin
          // Read data is combinational, so it is written back on the very next cycle.
          state_q     <= CP_WR;
          mem_we_o    <= 1'b1;
          mem_be_o    <= '1;
          mem_addr_o  <= dst_q;
          mem_wdata_o <= mem_rdata_i;
          dst_q       <= dst_q + STEP;
        end
        CP_WR: begin
          cnt_q <= cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_q     <= DONE;
            done_o      <= 1'b1;
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
          end else begin
            state_q    <= CP_RD;
            mem_we_o   <= 1'b0;
            mem_be_o   <= '0;
            mem_addr_o <= src_q;
            src_q      <= src_q + STEP;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_o   <= 1'b0;
          mem_en_o <= 1'b0;
          mem_we_o <= 1'b0;
          mem_be_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_dma.sv
// Bench for sp_ram_dma: behavioural RAM, per-cycle expected bus trace built from
// command semantics, plus literal checks on timing, wrap and copy results.
module tb_sp_ram_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [7:0]  src = '0;
  logic [7:0]  dst = '0;
  logic [7:0]  len = '0;
  logic [31:0] fill = '0;
  logic        busy, done, err, mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  sp_ram_dma #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
    .src_addr_i(src), .dst_addr_i(dst), .len_i(len), .fill_data_i(fill),
    .busy_o(busy), .done_o(done), .err_o(err),
    .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural 64-word RAM on the DUT port, plus a log of write addresses.
  logic [31:0] ram [64] = '{default: 32'h0};
  logic [7:0]  wr_log [$];
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wr_log.push_back(mem_addr);
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, start_cyc = 0;
  bit chk_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit        busy, done, err, en, we;
    bit [3:0]  be;
    bit [7:0]  addr;
    bit [31:0] wdata;
  } exp_t;

  exp_t        expq [$];
  logic [31:0] ref_mem [64] = '{default: 32'h0};

  // One compare per cycle: either the next queued bus expectation or a quiet port.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin done_cnt++; done_cyc = cyc; end
    if (rst_n && err)  begin err_cnt++;  err_cyc  = cyc; end
    if (rst_n && chk_on) begin
      e = '{default: 0};
      if (expq.size() > 0) e = expq.pop_front();
      chk("busy", 64'(busy), 64'(e.busy));
      chk("done", 64'(done), 64'(e.done));
      chk("err",  64'(err),  64'(e.err));
      chk("en",   64'(mem_en), 64'(e.en));
      chk("we",   64'(mem_we), 64'(e.we));
      chk("be",   64'(mem_be), 64'(e.be));
      if (e.en) chk("addr", 64'(mem_addr), 64'(e.addr));
      if (e.we) begin
        chk("wdata", 64'(mem_wdata), 64'(e.wdata));
        ref_mem[e.addr[7:2]] = e.wdata;
      end
    end
  end

  // Drive one command, and after its accepting edge queue the bus trace it must produce.
  task automatic launch(input bit o, input bit [7:0] s, input bit [7:0] d,
                        input bit [7:0] l, input bit [31:0] f);
    exp_t        e;
    logic [31:0] tmp [64];
    bit [7:0]    a;
    start = 1'b1; op = o; src = s; dst = d; len = l; fill = f;
    start_cyc = cyc;
    @(posedge clk);
    if ((d[1:0] != 2'b0) || (o && (s[1:0] != 2'b0))) begin
      e = '{default: 0}; e.err = 1; expq.push_back(e);
    end else begin
      tmp = ref_mem;
      for (int i = 0; i < int'(l); i++) begin
        if (o) begin
          a = s + 8'(4 * i);
          e = '{default: 0}; e.busy = 1; e.en = 1; e.addr = a;
          expq.push_back(e);
          e.we = 1; e.be = 4'hF; e.addr = d + 8'(4 * i); e.wdata = tmp[a[7:2]];
        end else begin
          e = '{default: 0}; e.busy = 1; e.en = 1; e.we = 1; e.be = 4'hF;
          e.addr = d + 8'(4 * i); e.wdata = f;
        end
        tmp[e.addr[7:2]] = e.wdata;
        expq.push_back(e);
      end
      e = '{default: 0}; e.busy = 1; e.done = 1; expq.push_back(e);
    end
    #1 start = 1'b0;
  endtask

  task automatic issue(input bit o, input bit [7:0] s, input bit [7:0] d,
                       input bit [7:0] l, input bit [31:0] f);
    int n = 0;
    launch(o, s, d, l, f);
    while (expq.size() != 0 && n < 600) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_timeout", 64'(expq.size()), 64'd0);
    expq.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int dc;
    bit [7:0] rs, rd, rl;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err",  64'(err),  64'd0);
    chk("rst_en",   64'(mem_en), 64'd0);
    chk("rst_we",   64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_be",   64'(mem_be), 64'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // FILL dst=0x10 len=4: done lands 5 cycles after the start cycle
    wr_log.delete();
    issue(1'b0, 8'h00, 8'h10, 8'd4, 32'hA5A5A5A5);
    chk("fill_done_lat", 64'(done_cyc - start_cyc), 64'd5);
    chk("fill_nwr", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      chk("fill_a0", 64'(wr_log[0]), 64'h10);
      chk("fill_a3", 64'(wr_log[3]), 64'h1C);
    end
    for (int w = 4; w < 8; w++) chk("fill_ram", 64'(ram[w]), 64'hA5A5A5A5);

    // Preload words 0..2 with 1,2,3 then COPY 0x00 -> 0x40 len=3
    issue(1'b0, 8'h00, 8'h00, 8'd1, 32'd1);
    issue(1'b0, 8'h00, 8'h04, 8'd1, 32'd2);
    issue(1'b0, 8'h00, 8'h08, 8'd1, 32'd3);
    dc = done_cnt;
    issue(1'b1, 8'h00, 8'h40, 8'd3, 32'hDEAD_BEEF);
    chk("copy_done_cnt", 64'(done_cnt - dc), 64'd1);
    chk("copy_done_lat", 64'(done_cyc - start_cyc), 64'd7);
    chk("copy_w0", 64'(ram[16]), 64'd1);
    chk("copy_w1", 64'(ram[17]), 64'd2);
    chk("copy_w2", 64'(ram[18]), 64'd3);

    // len=0 and misaligned destination: single pulse, no RAM access
    issue(1'b0, 8'h00, 8'h20, 8'd0, 32'h1);
    chk("len0_lat", 64'(done_cyc - start_cyc), 64'd1);
    dc = err_cnt;
    issue(1'b0, 8'h00, 8'h02, 8'd4, 32'h1);
    chk("err_lat", 64'(err_cyc - start_cyc), 64'd1);
    chk("err_cnt", 64'(err_cnt - dc), 64'd1);
    issue(1'b1, 8'h01, 8'h40, 8'd2, 32'h1);

    // Overlapping copy with dst>src replicates word 0
    issue(1'b1, 8'h00, 8'h04, 8'd3, 32'h0);
    chk("ovl_w3", 64'(ram[3]), 64'd1);

    // Address wrap
    wr_log.delete();
    issue(1'b0, 8'h00, 8'hF8, 8'd4, 32'h5A5A_0001);
    chk("wrap_nwr", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      chk("wrap_a0", 64'(wr_log[0]), 64'hF8);
      chk("wrap_a1", 64'(wr_log[1]), 64'hFC);
      chk("wrap_a2", 64'(wr_log[2]), 64'h00);
      chk("wrap_a3", 64'(wr_log[3]), 64'h04);
    end
    chk("wrap_ram0", 64'(ram[0]), 64'h5A5A_0001);

    // Start during COPY is ignored; reset during CP_WR abandons the command
    dc = done_cnt;
    launch(1'b1, 8'h80, 8'hC0, 8'd3, 32'h0);
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; dst = 8'h30; len = 8'd8; fill = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_en",   64'(mem_en), 64'd0);
    chk("mid_rst_we",   64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_nodone", 64'(done_cnt - dc), 64'd0);
    chk("mid_rst_w1", 64'(ram[49]), 64'(ref_mem[49]));

    // Random FILL/COPY mix against the reference contents
    for (int k = 0; k < 24; k++) begin
      rs = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) begin rs[1:0] = 2'b0; rd[1:0] = 2'b0; end
      issue(1'($urandom_range(0, 1)), rs, rd, rl, $urandom());
    end

    for (int w = 0; w < 64; w++) chk("ram_final", 64'(ram[w]), 64'(ref_mem[w]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
